// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch queue between the fetch PC / instruction memory and the
// IF/ID register. Issues word fetches over a req/gnt/rvalid handshake, keeps up
// to DEPTH instructions with their PCs, presents the oldest one to decode and
// flushes on a taken branch.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   br_taken            redirect: flush queue and in-flight fetches
//   BranchTarget        new fetch PC, sampled when br_taken=1
//   StallD              decode not accepting; head is held
//   imem_req/imem_addr  fetch request and word address (held until grant)
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   in-order fetch response
//   ValidF/InstF/AddrF  head entry valid, its instruction (NOP if empty), its PC

module inst_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] BranchTarget,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ValidF,
  output logic [31:0] InstF,
  output logic [31:0] AddrF
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] resv_q, resv_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [CntW-1:0] reserved_q, reserved_d;
  // Granted fetches whose data will land in the queue (reserved minus filled).
  logic [CntW-1:0] pending_q, pending_d;
  // Responses still owed for fetches issued before a redirect; they are dropped.
  logic [CntW-1:0] discard_q, discard_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [31:0] pc_q   [DEPTH];
  logic [31:0] inst_q [DEPTH];

  logic issue_ok;
  logic grant;
  logic fill_en;
  logic drop;
  logic pop;

  // Outstanding fetches (kept + dropped) never exceed the number of slots.
  assign issue_ok = ({1'b0, reserved_q} + {1'b0, discard_q}) < DepthLim;
  assign imem_req  = rst & ~br_taken & issue_ok;
  assign imem_addr = fetch_pc_q;

  assign grant   = imem_req & imem_gnt;
  assign fill_en = imem_rvalid & (discard_q == '0) & ~br_taken;
  assign drop    = imem_rvalid & (discard_q != '0);

  assign ValidF = filled_q[head_q] & (reserved_q != '0);
  assign InstF  = ValidF ? inst_q[head_q] : Nop;
  assign AddrF  = ValidF ? pc_q[head_q] : 32'h0;

  // A head that is valid during a redirect is flushed, not consumed.
  assign pop = ValidF & ~StallD & ~br_taken;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    resv_d     = resv_q;
    fill_d     = fill_q;
    reserved_d = reserved_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    filled_d   = filled_q;

    if (br_taken) begin
      fetch_pc_d = BranchTarget;
      head_d     = '0;
      resv_d     = '0;
      fill_d     = '0;
      reserved_d = '0;
      pending_d  = '0;
      filled_d   = '0;
      // Every fetch still in flight, kept or already doomed, becomes a drop;
      // a response arriving this cycle retires one of them. No grant is
      // possible here because the request is masked.
      discard_d  = discard_q + pending_q - CntW'(imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc_d       = fetch_pc_q + 32'd4;
        resv_d           = resv_q + PtrW'(1);
        filled_d[resv_q] = 1'b0;
      end
      if (fill_en) begin
        fill_d           = fill_q + PtrW'(1);
        filled_d[fill_q] = 1'b1;
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      unique case ({grant, pop})
        2'b10:   reserved_d = reserved_q + CntW'(1);
        2'b01:   reserved_d = reserved_q - CntW'(1);
        default: reserved_d = reserved_q;
      endcase
      unique case ({grant, fill_en})
        2'b10:   pending_d = pending_q + CntW'(1);
        2'b01:   pending_d = pending_q - CntW'(1);
        default: pending_d = pending_q;
      endcase
      if (drop) begin
        discard_d = discard_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      resv_q     <= '0;
      fill_q     <= '0;
      reserved_q <= '0;
      pending_q  <= '0;
      discard_q  <= '0;
      filled_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      resv_q     <= resv_d;
      fill_q     <= fill_d;
      reserved_q <= reserved_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      filled_q   <= filled_d;
    end
  end

  // Payload storage needs no reset: its contents are only visible through
  // the filled flags.
  always_ff @(posedge clk) begin
    if (grant) begin
      pc_q[resv_q] <= fetch_pc_q;
    end
    if (fill_en) begin
      inst_q[fill_q] <= imem_rdata;
    end
  end

endmodule

// File: doc/inst_prefetch_buffer.md
# inst_prefetch_buffer

Fetch-side instruction prefetch queue between the program counter / instruction memory and the IF/ID pipeline register (`first_register`). It issues word fetches to a multi-cycle instruction memory over a request/grant/response handshake and holds up to DEPTH fetched instructions with their PCs. It presents the oldest instruction to decode, honours `StallD` backpressure, and flushes on a taken branch. It replaces the single-cycle `Instruction_Memory` path so the core tolerates variable-latency memory.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `br_taken`  in  1  redirect: flush queue and in-flight fetches.
- `BranchTarget`  in  32  new fetch PC, sampled when `br_taken`=1.
- `StallD`  in  1  decode not accepting; head is not popped.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word address of request (bits[1:0]=0).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; responses arrive in request order.
- `imem_rdata`  in  32  response instruction.
- `ValidF`  out  1  head entry holds a filled instruction.
- `InstF`  out  32  head instruction; 32'h0000_0013 (NOP) when `ValidF`=0.
- `AddrF`  out  32  PC of head instruction; 0 when `ValidF`=0.

## Operation
- State: `fetch_pc`, DEPTH entries {pc, inst, filled}, pointers `head`, `resv` (next slot to reserve), `fill` (next slot to fill), count `reserved` (0..DEPTH), drop counter `discard` (0..DEPTH).
- Issue: `imem_req` = !`br_taken` && (`reserved` + `discard` < DEPTH); `imem_addr` = `fetch_pc`. Req/addr stable until `gnt`.
- On req&&gnt: write `fetch_pc` into entry[`resv`].pc, clear filled, `resv`++, `reserved`++, `fetch_pc` += 4 (mod 2^32 wrap).
- On rvalid: if `discard`>0, drop data, `discard`--; else write entry[`fill`].inst, set filled, `fill`++.
- Pop: `ValidF` = entry[`head`].filled && `reserved`>0. Pop when `ValidF` && !`StallD`: `head`++, `reserved`--. Pointers wrap modulo DEPTH.
- Simultaneous grant and pop: `reserved` unchanged.
- Redirect (`br_taken`=1) overrides grant/fill/pop bookkeeping for the queue: all entries unfilled, `head`=`resv`=`fill`=0, `reserved`=0, `fetch_pc`=`BranchTarget`. `discard_next` = `discard` + (`reserved` − filled-count) − (rvalid ? 1 : 0) + (req&&gnt ? 1 : 0). `imem_req` is forced 0 that cycle, so the grant term is 0 by construction.
- Pop is suppressed in a redirect cycle. A head valid in that cycle is discarded, not consumed.
- Memory contract, not checked: rvalid never in the same cycle as its own gnt; no rvalid without an outstanding request.
- Invariant: outstanding fetches (`reserved` − filled + `discard`) ≤ DEPTH.

## Timing
- Reset values: `imem_req`=0 while `rst`=0. `ValidF`=0, `InstF`=32'h13, `AddrF`=0. `fetch_pc`=`RESET_PC`, all counters/pointers 0, all entries unfilled.
- First cycle after reset release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Fetch latency: gnt at cycle N, rvalid at N+k (k≥1) → `ValidF` high at N+k+1 (entry registered, head read combinationally).
- Redirect at cycle R: `imem_req` low at R; request to `BranchTarget` at R+1.
  - With zero-wait memory (gnt at R+1, rvalid at R+2) and no discards pending, `AddrF`=`BranchTarget` at R+3.
- Full: `reserved`=DEPTH blocks issue. A pop at cycle N allows `imem_req` at N+1.
- Back-to-back: a zero-wait memory with constant `imem_gnt`=1 sustains one instruction per cycle with `StallD`=0.
- Asynchronous reset mid-operation clears all state immediately. Responses from pre-reset requests are the memory's responsibility to squash.

## Test plan
- Reset/stream: `rst`=0 5 cycles, then `RESET_PC`=0, gnt=1, rvalid one cycle after gnt, `StallD`=0. Expect `ValidF` from cycle 3, `AddrF`=0,4,8,C… consecutively with matching `InstF`.
- Backpressure: `StallD`=1 for 12 cycles, DEPTH=4. Expect exactly 4 grants, `imem_req`=0 afterwards, `AddrF` frozen. Release: 4 pops in order, then `imem_req` resumes next cycle.
- Redirect with 2 pending: fetches at 0x10, 0x14 granted but unanswered; `br_taken`=1, `BranchTarget`=0x200. Expect `discard`=2, both responses dropped, next `ValidF` with `AddrF`=0x200.
- Redirect coinciding with rvalid and pop: 1 pending, head valid, `StallD`=0. Expect the head not counted as popped, the arriving rvalid dropped, `discard`=0, and the next `imem_addr`=`BranchTarget`.
- Slow memory (gnt after 2 cycles, rvalid 3 cycles later) with PC wrap from 32'hFFFF_FFFC. Expect `AddrF` sequence FFFF_FFFC, 0000_0000, and `imem_addr` held stable while gnt=0.
- Async reset asserted mid-burst with queue 3/4 full. Expect outputs at reset values within the same cycle and the fetch restarting at `RESET_PC` after release.
